// File: rtl/grid_stream_loader.sv
// grid_stream_loader: parses an '@'/'.' byte stream into a DEPTH x WIDTH bit grid
// and holds the completed grid for the consumer until it is acknowledged.
module grid_stream_loader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             grid_ack,
    output logic [WIDTH-1:0] mat_out [DEPTH],
    output logic             grid_valid,
    output logic             error,
    output logic [1:0]       err_code
);
    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int ROW_W = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_ERROR = 2'd2;

    localparam logic [COL_W-1:0] COL_FULL = COL_W'(WIDTH);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DEPTH - 1);

    localparam logic [7:0] CH_PAPER = 8'h40;
    localparam logic [7:0] CH_EMPTY = 8'h2E;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    localparam logic [1:0] ERR_CHAR  = 2'd1;
    localparam logic [1:0] ERR_LONG  = 2'd2;
    localparam logic [1:0] ERR_SHORT = 2'd3;

    logic [1:0]       state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [WIDTH-1:0] row_buf;

    logic accept;
    logic is_cell;
    logic is_paper;
    logic is_cr;
    logic is_lf;
    logic row_full;
    logic last_row;
    logic cell_write;
    logic commit;

    // Handshake and status are pure decodes of the state register.
    assign in_ready   = (state == ST_LOAD) && !reset;
    assign grid_valid = (state == ST_HOLD);
    assign error      = (state == ST_ERROR);

    assign accept     = (state == ST_LOAD) && in_valid;
    assign is_paper   = (in_data == CH_PAPER);
    assign is_cell    = is_paper || (in_data == CH_EMPTY);
    assign is_cr      = (in_data == CH_CR);
    assign is_lf      = (in_data == CH_LF);
    assign row_full   = (col == COL_FULL);
    assign last_row   = (row == ROW_LAST);
    assign cell_write = accept && is_cell && !row_full;
    assign commit     = accept && is_lf && row_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_LOAD;
            col      <= '0;
            row      <= '0;
            err_code <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid) begin
                        if (is_cell) begin
                            if (row_full) begin
                                state    <= ST_ERROR;
                                err_code <= ERR_LONG;
                            end else begin
                                col <= col + COL_W'(1);
                            end
                        end else if (is_lf) begin
                            if (!row_full) begin
                                state    <= ST_ERROR;
                                err_code <= ERR_SHORT;
                            end else begin
                                col <= '0;
                                if (last_row) begin
                                    state <= ST_HOLD;
                                    row   <= '0;
                                end else begin
                                    row <= row + ROW_W'(1);
                                end
                            end
                        end else if (!is_cr) begin
                            state    <= ST_ERROR;
                            err_code <= ERR_CHAR;
                        end
                    end
                end
                ST_HOLD: begin
                    if (grid_ack) begin
                        state <= ST_LOAD;
                    end
                end
                default: begin
                    // ERROR is left only through reset
                end
            endcase
        end
    end

    // Every column is rewritten before a commit is allowed, so no reset is needed.
    always_ff @(posedge clk) begin
        if (cell_write) begin
            for (int c = 0; c < WIDTH; c++) begin
                if (col == COL_W'(c)) begin
                    row_buf[c] <= is_paper;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mat_out[r] <= '0;
            end
        end else if (commit) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (row == ROW_W'(r)) begin
                    mat_out[r] <= row_buf;
                end
            end
        end
    end
endmodule

// File: tb/tb_grid_stream_loader.sv
// Bench for grid_stream_loader: a 4x2 and a default 16x16 instance driven by directed
// and random streams, checked every cycle against a text-level grid model.
module tb_grid_stream_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vld [2];
    logic [7:0]  dat [2];
    logic        ack [2];
    logic        rdy [2];
    logic        gv  [2];
    logic        er  [2];
    logic [1:0]  ec  [2];
    logic [3:0]  mat_s [2];
    logic [15:0] mat_b [16];

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    grid_stream_loader #(.WIDTH(4), .DEPTH(2)) dut_s (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_data(dat[0]),
        .in_ready(rdy[0]), .grid_ack(ack[0]), .mat_out(mat_s),
        .grid_valid(gv[0]), .error(er[0]), .err_code(ec[0])
    );

    grid_stream_loader dut_b (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_data(dat[1]),
        .in_ready(rdy[1]), .grid_ack(ack[1]), .mat_out(mat_b),
        .grid_valid(gv[1]), .error(er[1]), .err_code(ec[1])
    );

    // Model: mode 0 = loading, 1 = grid held, 2 = failed
    int          mw [2] = '{4, 16};
    int          md [2] = '{2, 16};
    logic [15:0] m_mat [2][16];
    logic [15:0] m_buf [2];
    int          m_col [2];
    int          m_row [2];
    int          m_mode [2];
    int          m_code [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 16; r++) m_mat[d][r] = '0;
            m_buf[d] = '0;
            m_col[d] = 0;
            m_row[d] = 0;
            m_mode[d] = 0;
            m_code[d] = 0;
        end
    endtask

    task automatic model_fail(input int d, input int code);
        m_mode[d] = 2;
        m_code[d] = code;
    endtask

    task automatic model_edge(input int d);
        logic [7:0] b;
        if (m_mode[d] == 1) begin
            if (ack[d]) m_mode[d] = 0;
            return;
        end
        if (m_mode[d] != 0 || !vld[d]) return;
        b = dat[d];
        if (b == 8'h40 || b == 8'h2E) begin
            if (m_col[d] == mw[d]) model_fail(d, 2);
            else begin
                m_buf[d][m_col[d]] = (b == 8'h40);
                m_col[d]++;
            end
        end else if (b == 8'h0A) begin
            if (m_col[d] != mw[d]) model_fail(d, 3);
            else begin
                m_mat[d][m_row[d]] = m_buf[d];
                m_col[d] = 0;
                if (m_row[d] == md[d] - 1) begin
                    m_mode[d] = 1;
                    m_row[d] = 0;
                end else begin
                    m_row[d]++;
                end
            end
        end else if (b != 8'h0D) begin
            model_fail(d, 1);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else begin
                model_edge(0);
                model_edge(1);
            end
        end
    end

    task automatic chk(input string nm, input int idx, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, idx, $time, act, exp);
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("in_ready", d, longint'(rdy[d]), longint'(m_mode[d] == 0 && !reset));
                chk("grid_valid", d, longint'(gv[d]), longint'(m_mode[d] == 1));
                chk("error", d, longint'(er[d]), longint'(m_mode[d] == 2));
                chk("err_code", d, longint'(ec[d]), longint'(m_code[d]));
            end
            for (int r = 0; r < 2; r++) chk("mat_s", r, longint'(mat_s[r]), longint'(m_mat[0][r][3:0]));
            for (int r = 0; r < 16; r++) chk("mat_b", r, longint'(mat_b[r]), longint'(m_mat[1][r]));
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [7:0] b);
        logic r;
        int n;
        n = 0;
        vld[d] = 1'b1;
        dat[d] = b;
        forever begin
            @(negedge clk);
            r = rdy[d];
            tick();
            if (r) break;
            n++;
            if (n > 40) begin
                total++;
                $display("FAIL send_timeout[%0d] at %0t: got no accept, expected accept within 40 cycles", d, $time);
                break;
            end
        end
    endtask

    task automatic send_str(input int d, input string s, input int maxgap);
        for (int i = 0; i < s.len(); i++) begin
            int g;
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (g) begin
                vld[d] = 1'b0;
                dat[d] = 8'($urandom);
                tick();
            end
            send(d, s[i]);
        end
        vld[d] = 1'b0;
    endtask

    task automatic pulse_ack(input int d);
        ack[d] = 1'b1;
        tick();
        ack[d] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic string rand_grid(input int w, input int h, input bit crlf);
        string s;
        s = "";
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) s = {s, ($urandom_range(1, 0) == 1) ? "@" : "."};
            if (crlf && $urandom_range(1, 0) == 1) s = {s, "\r"};
            s = {s, "\n"};
        end
        return s;
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            vld[d] = 1'b0;
            dat[d] = 8'h00;
            ack[d] = 1'b0;
        end
        tick();
        tick();
        chk("reset_grid_valid", 0, longint'(gv[0]), 0);
        chk("reset_error", 0, longint'(er[0]), 0);
        chk("reset_err_code", 0, longint'(ec[0]), 0);
        chk("reset_in_ready", 0, longint'(rdy[0]), 0);
        chk("reset_mat", 0, longint'(mat_s[0]), 0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 0, longint'(rdy[0]), 1);

        // T1
        send_str(0, "@.@@\n.@..\n", 0);
        chk("t1_row0", 0, longint'(mat_s[0]), 'b1101);
        chk("t1_row1", 1, longint'(mat_s[1]), 'b0010);
        chk("t1_grid_valid", 0, longint'(gv[0]), 1);
        chk("t1_in_ready", 0, longint'(rdy[0]), 0);

        // T3: bytes offered in HOLD are refused
        vld[0] = 1'b1;
        dat[0] = 8'h40;
        repeat (5) tick();
        chk("t3_hold_row0", 0, longint'(mat_s[0]), 'b1101);
        chk("t3_hold_valid", 0, longint'(gv[0]), 1);
        vld[0] = 1'b0;
        pulse_ack(0);
        chk("t3_ready_after_ack", 0, longint'(rdy[0]), 1);
        chk("t3_valid_after_ack", 0, longint'(gv[0]), 0);
        send_str(0, "....\n@@@@\n", 0);
        chk("t3_row0", 0, longint'(mat_s[0]), 'b0000);
        chk("t3_row1", 1, longint'(mat_s[1]), 'b1111);
        pulse_ack(0);

        // T2: CRLF endings with random gaps
        send_str(0, "@.@@\r\n.@..\r\n", 3);
        chk("t2_row0", 0, longint'(mat_s[0]), 'b1101);
        chk("t2_row1", 1, longint'(mat_s[1]), 'b0010);
        chk("t2_grid_valid", 0, longint'(gv[0]), 1);
        pulse_ack(0);

        // T4: error cases
        do_reset();
        send(0, "x");
        chk("t4_char_error", 0, longint'(er[0]), 1);
        chk("t4_char_code", 0, longint'(ec[0]), 1);
        chk("t4_char_ready", 0, longint'(rdy[0]), 0);
        repeat (3) tick();
        chk("t4_char_sticky", 0, longint'(ec[0]), 1);
        vld[0] = 1'b0;
        pulse_ack(0);
        chk("t4_ack_ignored", 0, longint'(er[0]), 1);
        do_reset();
        send_str(0, "@@@@", 0);
        chk("t4_long_before", 0, longint'(ec[0]), 0);
        send(0, "@");
        vld[0] = 1'b0;
        chk("t4_long_code", 0, longint'(ec[0]), 2);
        do_reset();
        send_str(0, "@@\n", 0);
        chk("t4_short_code", 0, longint'(ec[0]), 3);

        // T5: asynchronous reset mid-load
        do_reset();
        send_str(0, "@.@@\n.@", 0);
        chk("t5_row0_committed", 0, longint'(mat_s[0]), 'b1101);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_mat", 0, longint'(mat_s[0]), 0);
        chk("t5_async_valid", 0, longint'(gv[0]), 0);
        chk("t5_async_ready", 0, longint'(rdy[0]), 0);
        tick();
        reset = 1'b0;
        send_str(0, "@.@@\n.@..\n", 0);
        chk("t5_row0", 0, longint'(mat_s[0]), 'b1101);
        chk("t5_row1", 1, longint'(mat_s[1]), 'b0010);
        pulse_ack(0);

        // T6: default-size instance
        begin
            string s;
            s = "";
            for (int r = 0; r < 16; r++) s = {s, "@.@.@.@.@.@.@.@.\n"};
            send_str(1, s, 1);
        end
        for (int r = 0; r < 16; r++) chk("t6_row", r, longint'(mat_b[r]), 'h5555);
        chk("t6_grid_valid", 1, longint'(gv[1]), 1);
        pulse_ack(1);

        // Random grids on both instances, with stray acks while loading
        for (int k = 0; k < 10; k++) begin
            pulse_ack(0);
            send_str(0, rand_grid(4, 2, 1'b1), 3);
            repeat ($urandom_range(3, 0)) tick();
            pulse_ack(0);
        end
        for (int k = 0; k < 2; k++) begin
            send_str(1, rand_grid(16, 16, 1'b1), 1);
            repeat ($urandom_range(3, 0)) tick();
            pulse_ack(1);
        end
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
